// File: rtl/rv_mc_ctrl.sv
// Multicycle RISC-V control unit: sequences FETCH..WRITE_BACK,
// decodes ALU/mux controls, handles memory waits and traps.
module rv_mc_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    input  logic [3:0]       alu_flags,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             i_mem_re,
    output logic             ir_we,
    output logic             d_mem_re,
    output logic             d_mem_we,
    output logic             rf_we,
    output logic             pc_we,
    output logic             pc_src,
    output logic             alu_src,
    output logic [1:0]       rf_src,
    output logic [3:0]       alu_cmd,
    output logic [2:0]       state,
    output logic             trap,
    output logic             trap_cause,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    localparam logic [3:0] A_ADD   = 4'b0000;
    localparam logic [3:0] A_SUB   = 4'b0001;
    localparam logic [3:0] A_AND   = 4'b0010;
    localparam logic [3:0] A_OR    = 4'b0011;
    localparam logic [3:0] A_XOR   = 4'b0100;
    localparam logic [3:0] A_SLT   = 4'b0101;
    localparam logic [3:0] A_SLTU  = 4'b0110;
    localparam logic [3:0] A_SLL   = 4'b0111;
    localparam logic [3:0] A_SRL   = 4'b1000;
    localparam logic [3:0] A_SRA   = 4'b1001;
    localparam logic [3:0] A_PASSB = 4'b1010;

    state_t           st_q;
    state_t           st_d;
    logic [7:0]       wait_q;
    logic [6:0]       op_q;
    logic [2:0]       f3_q;
    logic             f75_q;
    logic             taken_q;
    logic             trap_q;
    logic             cause_q;
    logic [CNT_W-1:0] ret_q;

    logic       set_trap;
    logic       set_cause;
    logic       legal;
    logic       wait_hit;
    logic       stalled;
    logic       br_cond;
    logic [3:0] cmd_dec;

    logic is_r, is_i, is_ld, is_st;
    logic is_br, is_jal, is_lui;

    assign is_r   = (op_q == OP_R);
    assign is_i   = (op_q == OP_I);
    assign is_ld  = (op_q == OP_LD);
    assign is_st  = (op_q == OP_ST);
    assign is_br  = (op_q == OP_BR);
    assign is_jal = (op_q == OP_JAL);
    assign is_lui = (op_q == OP_LUI);

    // Legality is judged on the live IR fields while in DECODE.
    assign legal = (opcode == OP_R)  || (opcode == OP_I)
                || (opcode == OP_LD) || (opcode == OP_ST)
                || (opcode == OP_JAL) || (opcode == OP_LUI)
                || ((opcode == OP_BR) && (funct3[2:1] != 2'b01));

    assign wait_hit = (wait_q == 8'(MEM_TIMEOUT));
    assign stalled  = ((st_q == S_FETCH) && !imem_ready)
                   || ((st_q == S_MEM) && !dmem_ready);

    always_comb begin
        st_d      = st_q;
        set_trap  = 1'b0;
        set_cause = 1'b0;
        unique case (st_q)
            S_IDLE:   if (run) st_d = S_FETCH;
            S_FETCH: begin
                if (imem_ready) begin
                    st_d = S_DECODE;
                end else if (wait_hit) begin
                    st_d      = S_TRAP;
                    set_trap  = 1'b1;
                    set_cause = 1'b1;
                end
            end
            S_DECODE: begin
                if (legal) begin
                    st_d = S_EXEC;
                end else begin
                    st_d     = S_TRAP;
                    set_trap = 1'b1;
                end
            end
            S_EXEC:   st_d = (is_ld || is_st) ? S_MEM : S_WB;
            S_MEM: begin
                if (dmem_ready) begin
                    st_d = S_WB;
                end else if (wait_hit) begin
                    st_d      = S_TRAP;
                    set_trap  = 1'b1;
                    set_cause = 1'b1;
                end
            end
            S_WB:     st_d = S_FETCH;
            S_TRAP:   st_d = S_TRAP;
            default:  st_d = S_IDLE;
        endcase
    end

    // Flags order is {C, V, N, Z}.
    always_comb begin
        br_cond = 1'b0;
        case (f3_q)
            3'b000:  br_cond = alu_flags[0];
            3'b001:  br_cond = !alu_flags[0];
            3'b100:  br_cond = alu_flags[1] ^ alu_flags[2];
            3'b101:  br_cond = !(alu_flags[1] ^ alu_flags[2]);
            3'b110:  br_cond = !alu_flags[3];
            3'b111:  br_cond = alu_flags[3];
            default: br_cond = 1'b0;
        endcase
    end

    always_comb begin
        cmd_dec = A_ADD;
        case (f3_q)
            3'b000:  cmd_dec = (is_r && f75_q) ? A_SUB : A_ADD;
            3'b111:  cmd_dec = A_AND;
            3'b110:  cmd_dec = A_OR;
            3'b100:  cmd_dec = A_XOR;
            3'b010:  cmd_dec = A_SLT;
            3'b011:  cmd_dec = A_SLTU;
            3'b001:  cmd_dec = A_SLL;
            3'b101:  cmd_dec = f75_q ? A_SRA : A_SRL;
            default: cmd_dec = A_ADD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q    <= S_IDLE;
            wait_q  <= '0;
            op_q    <= '0;
            f3_q    <= '0;
            f75_q   <= 1'b0;
            taken_q <= 1'b0;
            trap_q  <= 1'b0;
            cause_q <= 1'b0;
            ret_q   <= '0;
        end else begin
            st_q <= st_d;
            if (st_d != st_q)
                wait_q <= '0;
            else if (stalled)
                wait_q <= wait_q + 8'd1;
            if (st_q == S_DECODE) begin
                op_q  <= opcode;
                f3_q  <= funct3;
                f75_q <= funct7_5;
            end
            if (st_q == S_EXEC)
                taken_q <= br_cond;
            if (set_trap) begin
                trap_q  <= 1'b1;
                cause_q <= set_cause;
            end
            if (st_q == S_WB)
                ret_q <= ret_q + CNT_W'(1);
        end
    end

    always_comb begin
        i_mem_re = (st_q == S_FETCH);
        ir_we    = (st_q == S_FETCH) && imem_ready;
        d_mem_re = 1'b0;
        d_mem_we = 1'b0;
        rf_we    = 1'b0;
        pc_we    = 1'b0;
        pc_src   = 1'b0;
        alu_src  = 1'b0;
        rf_src   = 2'b00;
        alu_cmd  = A_ADD;
        // Datapath selects stay put from EXECUTE through WRITE_BACK.
        if (st_q == S_EXEC || st_q == S_MEM || st_q == S_WB) begin
            unique case (1'b1)
                is_r:   alu_cmd = cmd_dec;
                is_i: begin
                    alu_cmd = cmd_dec;
                    alu_src = 1'b1;
                end
                is_ld: begin
                    alu_src = 1'b1;
                    rf_src  = 2'b01;
                end
                is_st:  alu_src = 1'b1;
                is_br:  alu_cmd = A_SUB;
                is_jal: rf_src = 2'b10;
                is_lui: begin
                    alu_cmd = A_PASSB;
                    alu_src = 1'b1;
                end
                default: alu_cmd = A_ADD;
            endcase
        end
        if (st_q == S_MEM) begin
            d_mem_re = is_ld;
            d_mem_we = is_st;
        end
        if (st_q == S_WB) begin
            pc_we  = 1'b1;
            pc_src = is_jal || (is_br && taken_q);
            rf_we  = is_r || is_i || is_ld
                  || is_jal || is_lui;
        end
    end

    assign state      = st_q;
    assign trap       = trap_q;
    assign trap_cause = cause_q;
    assign instret    = ret_q;

endmodule

// File: tb/tb_rv_mc_ctrl.sv
// Scoreboard bench for rv_mc_ctrl: expected per-instruction results are
// queued at issue and compared once the instruction retires or traps.
module tb_rv_mc_ctrl;

    localparam int TO = 15;
    localparam int CW = 3;

    localparam logic [6:0] R   = 7'b0110011;
    localparam logic [6:0] I   = 7'b0010011;
    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] LUI = 7'b0110111;

    typedef struct packed {
        logic [3:0]  alu_cmd;
        logic        alu_src;
        logic [1:0]  rf_src;
        logic        rf_we;
        logic        pc_src;
        logic [7:0]  cycles;
        logic [7:0]  dcyc;
        logic [3:0]  ir_n;
        logic [3:0]  pc_n;
        logic [3:0]  rf_n;
        logic [23:0] trace;
        logic        trapped;
        logic        tmo;
        logic [2:0]  instret;
    } res_t;

    logic          clk;
    logic          reset;
    logic          run;
    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic          funct7_5;
    logic [3:0]    alu_flags;
    logic          imem_ready;
    logic          dmem_ready;
    logic          i_mem_re;
    logic          ir_we;
    logic          d_mem_re;
    logic          d_mem_we;
    logic          rf_we;
    logic          pc_we;
    logic          pc_src;
    logic          alu_src;
    logic [1:0]    rf_src;
    logic [3:0]    alu_cmd;
    logic [2:0]    state;
    logic          trap;
    logic          trap_cause;
    logic [CW-1:0] instret;

    int   n_chk;
    int   n_fail;
    int   exp_ret;
    res_t exp_q[$];

    rv_mc_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .run(run),
        .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .alu_flags(alu_flags),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .i_mem_re(i_mem_re), .ir_we(ir_we),
        .d_mem_re(d_mem_re), .d_mem_we(d_mem_we),
        .rf_we(rf_we), .pc_we(pc_we), .pc_src(pc_src),
        .alu_src(alu_src), .rf_src(rf_src), .alu_cmd(alu_cmd),
        .state(state), .trap(trap), .trap_cause(trap_cause),
        .instret(instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] sh(input logic [23:0] t,
                                       input logic [2:0] s);
        return {t[20:0], s};
    endfunction

    function automatic logic [3:0] amap(input logic [2:0] f3,
                                        input logic f75,
                                        input bit sub_ok);
        case (f3)
            3'b000:  return (sub_ok && f75) ? 4'd1 : 4'd0;
            3'b111:  return 4'd2;
            3'b110:  return 4'd3;
            3'b100:  return 4'd4;
            3'b010:  return 4'd5;
            3'b011:  return 4'd6;
            3'b001:  return 4'd7;
            default: return f75 ? 4'd9 : 4'd8;
        endcase
    endfunction

    // Reference model of one instruction as seen from FETCH onward.
    function automatic res_t model(input logic [6:0] op,
                                   input logic [2:0] f3,
                                   input logic f75,
                                   input logic [3:0] fl,
                                   input int iw, input int dw,
                                   input logic [2:0] prev);
        res_t e;
        bit is_r, is_i, ld, st, br, jal, lui, legal, tk;
        logic c, v, n, z;
        e = '0;
        e.instret = prev;
        {c, v, n, z} = fl;
        is_r = (op == R);  is_i = (op == I);
        ld = (op == LD);   st = (op == ST);
        br = (op == BR);   jal = (op == JAL);
        lui = (op == LUI);
        legal = is_r || is_i || ld || st || jal || lui
             || (br && f3 != 3'b010 && f3 != 3'b011);
        if (iw > TO) begin
            for (int k = 0; k < TO + 1; k++) begin
                e.trace = sh(e.trace, 3'd1);
                e.cycles = e.cycles + 8'd1;
            end
            e.trace = sh(e.trace, 3'd6);
            e.trapped = 1'b1;
            return e;
        end
        for (int k = 0; k < iw + 1; k++) begin
            e.trace = sh(e.trace, 3'd1);
            e.cycles = e.cycles + 8'd1;
        end
        e.ir_n = 4'd1;
        e.trace = sh(e.trace, 3'd2);
        e.cycles = e.cycles + 8'd1;
        if (!legal) begin
            e.trace = sh(e.trace, 3'd6);
            e.trapped = 1'b1;
            return e;
        end
        e.trace = sh(e.trace, 3'd3);
        e.cycles = e.cycles + 8'd1;
        if (ld || st) begin
            int m;
            m = (dw > TO) ? TO + 1 : dw + 1;
            for (int k = 0; k < m; k++) begin
                e.trace = sh(e.trace, 3'd4);
                e.cycles = e.cycles + 8'd1;
            end
            e.dcyc = 8'(m);
            if (dw > TO) begin
                e.trace = sh(e.trace, 3'd6);
                e.trapped = 1'b1;
                return e;
            end
        end
        e.trace = sh(e.trace, 3'd5);
        e.cycles = e.cycles + 8'd1;
        e.pc_n = 4'd1;
        case (f3)
            3'b000:  tk = z;
            3'b001:  tk = !z;
            3'b100:  tk = n ^ v;
            3'b101:  tk = !(n ^ v);
            3'b110:  tk = !c;
            default: tk = c;
        endcase
        if (is_r) e.alu_cmd = amap(f3, f75, 1'b1);
        if (is_i) begin
            e.alu_cmd = amap(f3, f75, 1'b0);
            e.alu_src = 1'b1;
        end
        if (ld) begin e.alu_src = 1'b1; e.rf_src = 2'b01; end
        if (st) e.alu_src = 1'b1;
        if (br) e.alu_cmd = 4'd1;
        if (jal) e.rf_src = 2'b10;
        if (lui) begin e.alu_cmd = 4'd10; e.alu_src = 1'b1; end
        e.pc_src = jal || (br && tk);
        e.rf_we = is_r || is_i || ld || jal || lui;
        e.rf_n = {3'd0, e.rf_we};
        e.instret = prev + 3'd1;
        return e;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        run = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_ret = 0;
    endtask

    // Drives one instruction until WRITE_BACK retires or TRAP is entered.
    task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                         input logic f75, input logic [3:0] fl,
                         input int iw, input int dw,
                         output res_t r);
        int fc;
        int mc;
        bit done;
        r = '0;
        fc = 0;
        mc = 0;
        done = 1'b0;
        opcode = op;
        funct3 = f3;
        funct7_5 = f75;
        alu_flags = fl;
        for (int c = 0; c < 100 && !done; c++) begin
            imem_ready = (state == 3'd1) && (fc >= iw);
            dmem_ready = (state == 3'd4) && (mc >= dw);
            #1;
            if (state != 3'd0) r.trace = sh(r.trace, state);
            if (state >= 3'd1 && state <= 3'd5)
                r.cycles = r.cycles + 8'd1;
            if (state == 3'd1) fc++;
            if (state == 3'd4) mc++;
            r.dcyc = r.dcyc + 8'(d_mem_re | d_mem_we);
            r.ir_n = r.ir_n + 4'(ir_we);
            r.pc_n = r.pc_n + 4'(pc_we);
            r.rf_n = r.rf_n + 4'(rf_we);
            if (state == 3'd5) begin
                r.alu_cmd = alu_cmd;
                r.alu_src = alu_src;
                r.rf_src = rf_src;
                r.rf_we = rf_we;
                r.pc_src = pc_src;
            end
            if (state == 3'd6) begin
                r.trapped = 1'b1;
                done = 1'b1;
            end else begin
                if (state == 3'd5) done = 1'b1;
                @(posedge clk);
                #1;
            end
        end
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        r.tmo = !done;
        r.instret = instret;
    endtask

    task automatic push(input logic [6:0] op, input logic [2:0] f3,
                        input logic f75, input logic [3:0] fl,
                        input int iw, input int dw);
        res_t e;
        e = model(op, f3, f75, fl, iw, dw, 3'(exp_ret));
        if (!e.trapped) exp_ret = (exp_ret + 1) % (1 << CW);
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++;
        if (state !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %0d want 0", state);
        end
        n_chk++;
        if ({i_mem_re, ir_we, d_mem_re, d_mem_we, rf_we, pc_we,
             pc_src, alu_src, rf_src, alu_cmd} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got nonzero controls want 0");
        end
        n_chk++;
        if ({trap, trap_cause} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_trap: got %b want 00", {trap, trap_cause});
        end
        n_chk++;
        if (instret !== '0) begin
            n_fail++;
            $display("FAIL reset_instret: got %0d want 0", instret);
        end
    endtask

    task automatic test_add();
        res_t r, e;
        run = 1'b1;
        push(R, 3'b000, 1'b0, 4'd0, 0, 0);
        issue(R, 3'b000, 1'b0, 4'd0, 0, 0, r);
        e = exp_q.pop_front();
        n_chk++;
        if (r !== e) begin
            n_fail++;
            $display("FAIL add: got %h want %h", r, e);
        end
        n_chk++;
        if (r.trace[11:0] !== {3'd1, 3'd2, 3'd3, 3'd5}) begin
            n_fail++;
            $display("FAIL add_seq: got %o want 1235", r.trace[11:0]);
        end
    endtask

    task automatic test_load();
        res_t r, e;
        run = 1'b0;
        push(LD, 3'b010, 1'b0, 4'd0, 0, 3);
        issue(LD, 3'b010, 1'b0, 4'd0, 0, 3, r);
        e = exp_q.pop_front();
        n_chk++;
        if (r !== e) begin
            n_fail++;
            $display("FAIL load_wait: got %h want %h", r, e);
        end
        n_chk++;
        if (state !== 3'd1) begin
            n_fail++;
            $display("FAIL run_ignored: got state %0d want 1", state);
        end
        run = 1'b1;
    endtask

    task automatic test_branch();
        res_t r, e;
        push(BR, 3'b000, 1'b0, 4'b0001, 0, 0);
        issue(BR, 3'b000, 1'b0, 4'b0001, 0, 0, r);
        e = exp_q.pop_front();
        n_chk++;
        if (r !== e) begin
            n_fail++;
            $display("FAIL beq_taken: got %h want %h", r, e);
        end
        push(BR, 3'b100, 1'b0, 4'b0110, 1, 0);
        issue(BR, 3'b100, 1'b0, 4'b0110, 1, 0, r);
        e = exp_q.pop_front();
        n_chk++;
        if (r !== e) begin
            n_fail++;
            $display("FAIL blt_not_taken: got %h want %h", r, e);
        end
    endtask

    task automatic test_decode_table();
        logic [6:0] ops[16] = '{R, R, R, R, R, R, R, R,
                                I, I, LUI, JAL, ST, BR, BR, BR};
        logic [2:0] f3s[16] = '{3'b000, 3'b111, 3'b110, 3'b100,
                                3'b010, 3'b011, 3'b001, 3'b101,
                                3'b000, 3'b101, 3'b000, 3'b000,
                                3'b010, 3'b001, 3'b110, 3'b101};
        logic       f7s[16] = '{1, 0, 0, 0, 0, 0, 0, 1,
                                1, 0, 0, 0, 0, 0, 0, 0};
        logic [3:0] fls[16] = '{0, 0, 0, 0, 0, 0, 0, 0,
                                0, 0, 0, 0, 0, 4'b0000, 4'b1000,
                                4'b0010};
        res_t r, e;
        for (int k = 0; k < 16; k++) begin
            push(ops[k], f3s[k], f7s[k], fls[k], k % 3, 1);
            issue(ops[k], f3s[k], f7s[k], fls[k], k % 3, 1, r);
            e = exp_q.pop_front();
            n_chk++;
            if (r !== e) begin
                n_fail++;
                $display("FAIL decode_%0d: got %h want %h", k, r, e);
            end
        end
    endtask

    task automatic test_illegal();
        res_t r, e;
        bit bad;
        push(7'h7f, 3'b000, 1'b0, 4'd0, 0, 0);
        issue(7'h7f, 3'b000, 1'b0, 4'd0, 0, 0, r);
        e = exp_q.pop_front();
        n_chk++;
        if (r !== e) begin
            n_fail++;
            $display("FAIL illegal_op: got %h want %h", r, e);
        end
        bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            if (state !== 3'd6 || pc_we !== 1'b0) bad = 1'b1;
        end
        n_chk++;
        if (bad || {trap, trap_cause} !== 2'b10) begin
            n_fail++;
            $display("FAIL illegal_hold: got state %0d trap %b%b want 6 10",
                     state, trap, trap_cause);
        end
        do_reset();
        n_chk++;
        if ({state, trap} !== 4'd0) begin
            n_fail++;
            $display("FAIL trap_reset: got %0d %b want 0 0", state, trap);
        end
        run = 1'b1;
        push(BR, 3'b011, 1'b0, 4'd0, 0, 0);
        issue(BR, 3'b011, 1'b0, 4'd0, 0, 0, r);
        e = exp_q.pop_front();
        n_chk++;
        if (r !== e) begin
            n_fail++;
            $display("FAIL illegal_branch: got %h want %h", r, e);
        end
    endtask

    task automatic test_timeout();
        res_t r, e;
        do_reset();
        run = 1'b1;
        push(R, 3'b000, 1'b0, 4'd0, 1000, 0);
        issue(R, 3'b000, 1'b0, 4'd0, 1000, 0, r);
        e = exp_q.pop_front();
        n_chk++;
        if (r !== e || {trap, trap_cause} !== 2'b11) begin
            n_fail++;
            $display("FAIL imem_timeout: got %h %b want %h 11",
                     r, {trap, trap_cause}, e);
        end
        do_reset();
        run = 1'b1;
        push(R, 3'b000, 1'b0, 4'd0, TO, 0);
        issue(R, 3'b000, 1'b0, 4'd0, TO, 0, r);
        e = exp_q.pop_front();
        n_chk++;
        if (r !== e || trap !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_at_limit: got %h trap %b want %h 0",
                     r, trap, e);
        end
        push(LD, 3'b010, 1'b0, 4'd0, 0, 1000);
        issue(LD, 3'b010, 1'b0, 4'd0, 0, 1000, r);
        e = exp_q.pop_front();
        n_chk++;
        if (r !== e || {trap, trap_cause} !== 2'b11) begin
            n_fail++;
            $display("FAIL dmem_timeout: got %h %b want %h 11",
                     r, {trap, trap_cause}, e);
        end
    endtask

    task automatic test_back_to_back();
        res_t r, e;
        do_reset();
        run = 1'b1;
        for (int k = 0; k < 9; k++) begin
            push(I, 3'b101, 1'b1, 4'd0, 0, 0);
            issue(I, 3'b101, 1'b1, 4'd0, 0, 0, r);
            e = exp_q.pop_front();
            n_chk++;
            if (r !== e) begin
                n_fail++;
                $display("FAIL srai_%0d: got %h want %h", k, r, e);
            end
        end
        n_chk++;
        if (instret !== 3'd1) begin
            n_fail++;
            $display("FAIL instret_wrap: got %0d want 1", instret);
        end
    endtask

    task automatic test_reset_in_mem();
        do_reset();
        run = 1'b1;
        opcode = ST;
        funct3 = 3'b010;
        funct7_5 = 1'b0;
        imem_ready = 1'b1;
        dmem_ready = 1'b0;
        for (int c = 0; c < 20 && state != 3'd4; c++) begin
            @(posedge clk);
            #1;
        end
        imem_ready = 1'b0;
        #1;
        n_chk++;
        if (state !== 3'd4 || d_mem_we !== 1'b1) begin
            n_fail++;
            $display("FAIL store_mem: got state %0d we %b want 4 1",
                     state, d_mem_we);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_chk++;
        if (d_mem_we !== 1'b0 || state !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_in_mem: got we %b state %0d want 0 0",
                     d_mem_we, state);
        end
        reset = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        exp_ret = 0;
        reset = 1'b1;
        run = 1'b0;
        opcode = '0;
        funct3 = '0;
        funct7_5 = 1'b0;
        alu_flags = '0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        test_reset();
        test_add();
        test_load();
        test_branch();
        test_decode_table();
        test_illegal();
        test_timeout();
        test_back_to_back();
        test_reset_in_mem();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rv_mc_ctrl.md
# rv_mc_ctrl

Parametrised multicycle control unit for the RISC-V datapath (FD), replacing the fixed five-state controller. It sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WRITE_BACK and drives the datapath write enables, mux selects and ALU command. It adds memory ready handshakes with a wait-timeout, funct3/funct7-based ALU decode, full branch-condition evaluation from ALU flags, JAL/LUI support, an illegal-opcode trap and a retired-instruction counter.

## Interface
- MEM_TIMEOUT, 15: maximum wait cycles on a memory ready before a bus-error trap; 1..255.
- CNT_W, 32: width of the retired-instruction counter.
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- run  in  1  leave IDLE and start fetching.
- opcode  in  7  IR[6:0].
- funct3  in  3  IR[14:12].
- funct7_5  in  1  IR[30].
- alu_flags  in  4  {C, V, N, Z} = [3:0] bits {3,2,1,0} from the ALU.
- imem_ready  in  1  instruction memory data valid.
- dmem_ready  in  1  data memory access complete.
- i_mem_re  out  1  instruction read request.
- ir_we  out  1  IR load strobe.
- d_mem_re / d_mem_we  out  1 each  data memory read/write request.
- rf_we  out  1  register file write.
- pc_we  out  1  PC update.
- pc_src  out  1  0 = PC+4, 1 = PC+imm.
- alu_src  out  1  0 = rs2, 1 = imm.
- rf_src  out  2  00 = ALU, 01 = memory, 10 = PC+4.
- alu_cmd  out  4  ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 0111, SRL 1000, SRA 1001, PASSB 1010.
- state  out  3  current state, for debug.
- trap  out  1  sticky; set on illegal opcode or timeout.
- trap_cause  out  1  0 = illegal opcode, 1 = bus timeout.
- instret  out  CNT_W  count of retired instructions.

## Operation
- States: IDLE 0, FETCH 1, DECODE 2, EXECUTE 3, MEM 4, WRITE_BACK 5, TRAP 6.
- Transitions:
  - IDLE → FETCH when run = 1.
  - FETCH holds i_mem_re = 1 until imem_ready. In the ready cycle ir_we = 1, then the FSM goes to DECODE.
  - DECODE latches opcode, funct3 and funct7_5 into internal registers. Unsupported opcode → TRAP with cause 0. Otherwise → EXECUTE.
  - EXECUTE: LOAD/STORE → MEM; all other classes → WRITE_BACK.
  - MEM holds d_mem_re (LOAD) or d_mem_we (STORE) until dmem_ready, then → WRITE_BACK.
  - WRITE_BACK → FETCH.
  - TRAP holds until reset.
- Wait counter: counts cycles in FETCH/MEM with ready low and clears on state change. Reaching MEM_TIMEOUT with ready still low → TRAP with cause 1.
- Control outputs are a function of the state and the latched fields only, except the branch decision, which samples alu_flags during EXECUTE into a taken register.
- Decode:
  - R 0110011: alu_src 0. alu_cmd from funct3: 000 ADD, or SUB if funct7_5; 111 AND; 110 OR; 100 XOR; 010 SLT; 011 SLTU; 001 SLL; 101 SRL, or SRA if funct7_5. rf_src 00.
  - I-ALU 0010011: same map with alu_src 1, except 000 is always ADD.
  - LOAD 0000011 / STORE 0100011: ADD, alu_src 1. LOAD rf_src 01.
  - BRANCH 1100011: SUB, alu_src 0. Taken condition by funct3:
    - 000: Z.
    - 001: !Z.
    - 100: N^V.
    - 101: !(N^V).
    - 110: !C.
    - 111: C.
    - 010 and 011: illegal, detected in DECODE.
  - JAL 1101111: rf_src 10, pc_src 1.
  - LUI 0110111: PASSB, alu_src 1.
- WRITE_BACK:
  - pc_we = 1 for every class.
  - pc_src = 1 for JAL or a taken branch, else 0.
  - rf_we = 1 for R, I-ALU, LOAD, JAL and LUI.
- alu_cmd, alu_src and rf_src are held stable from EXECUTE through WRITE_BACK. In IDLE and FETCH they are 0.
- instret increments by 1 in each WRITE_BACK cycle and wraps modulo 2^CNT_W.

## Timing
- Reset: state = IDLE; all outputs 0; trap, trap_cause, instret, wait counter and latched fields are cleared. Reset overrides every state, including TRAP and a pending memory wait; requests drop the cycle after reset is sampled.
- Latency with zero memory wait (ready high on the first request cycle):
  - R, I-ALU, LUI, JAL, BRANCH: 4 cycles (F, D, E, WB).
  - LOAD, STORE: 5 cycles.
- Each wait cycle adds 1.
- ir_we, pc_we and rf_we are exactly one-cycle pulses per instruction.
- Requests (i_mem_re, d_mem_re, d_mem_we) stay asserted continuously until the ready cycle, inclusive. Ready while no request is pending is ignored.
- Ready arriving in the same cycle the wait count reaches MEM_TIMEOUT counts as success, not timeout.
- run is sampled only in IDLE; deasserting run mid-instruction has no effect.

## Test plan
- Reset, run = 1, ADD (0110011, f3 000, f7_5 0), memory always ready:
  - States 1, 2, 3, 5 in consecutive cycles.
  - alu_cmd 0000; rf_we and pc_we pulse in WB with pc_src 0; instret = 1.
- LOAD with dmem_ready delayed 3 cycles:
  - 8-cycle instruction; d_mem_re high for exactly 4 cycles.
  - rf_src 01 in WB.
- BEQ with Z = 1, then BLT with N = 1 and V = 1:
  - First: pc_src 1 in WB.
  - Second: pc_src 0; rf_we 0 for both.
- Opcode 1111111:
  - TRAP reached the cycle after DECODE; trap 1, trap_cause 0.
  - No pc_we; stays in TRAP until reset.
- MEM_TIMEOUT = 15, imem_ready held low:
  - TRAP with trap_cause 1 after 15 wait cycles.
  - Same setup with ready arriving exactly at count 15 → DECODE, no trap.
- CNT_W = 3, 9 back-to-back SRAI (0010011, f3 101, f7_5 1):
  - alu_cmd 1001, alu_src 1.
  - instret wraps to 1 after the ninth instruction.
  - Reset asserted in MEM of a store drops d_mem_we the next cycle and returns to IDLE.
